// File: rtl/pkt_head_upd_merger.sv
// Merges software head-pointer updates into the packet metadata stream, flagging
// packets that can carry the pending descriptor and emitting descriptor-only entries otherwise.
package pkt_head_upd_merger_pkg;

  localparam int unsigned QIDW = 16;

  typedef struct packed {
    logic [31:0]     pkt_addr;
    logic [15:0]     pkt_len;
    logic [QIDW-1:0] pkt_queue_id;
    logic            needs_dsc;
    logic            descriptor_only;
  } pkt_meta_with_queues_t;

endpackage

module pkt_head_upd_merger
  import pkt_head_upd_merger_pkg::*;
#(
  parameter int unsigned NB_QUEUES       = 512,
  parameter int unsigned HEAD_FIFO_DEPTH = 16,
  parameter int unsigned MAX_PKT_BURST   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  pkt_meta_with_queues_t        in_meta_data,
  input  logic                         in_meta_valid,
  output logic                         in_meta_ready,
  input  logic [$clog2(NB_QUEUES)-1:0] head_upd_queue_id,
  input  logic                         head_upd_valid,
  output logic                         head_upd_ready,
  output pkt_meta_with_queues_t        out_meta_data,
  output logic                         out_meta_valid,
  input  logic                         out_meta_ready,
  output logic [31:0]                  pkt_cnt,
  output logic [31:0]                  dsc_only_cnt,
  output logic [31:0]                  merged_cnt,
  output logic [31:0]                  dup_cnt
);

  localparam int unsigned QW = $clog2(NB_QUEUES);
  localparam int unsigned AW = $clog2(HEAD_FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(MAX_PKT_BURST + 1);

  logic [QW-1:0]        fifo_mem [HEAD_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic [NB_QUEUES-1:0] pending;
  logic [NB_QUEUES-1:0] pending_nxt;
  logic [BW-1:0]        burst_cnt;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  slot_free;
  logic                  head_turn;
  logic [QW-1:0]         pkt_q;
  logic [QW-1:0]         head_q;
  logic                  pkt_fire;
  logic                  hu_fire;
  logic                  pop;
  logic                  pkt_merge;
  logic                  pop_live;
  logic                  hu_dup;
  logic                  push;
  pkt_meta_with_queues_t pkt_out;
  pkt_meta_with_queues_t dsc_out;

  // Arbitration between the packet stream and queued head updates
  assign fifo_empty     = (fifo_cnt == '0);
  assign fifo_full      = (fifo_cnt == CW'(HEAD_FIFO_DEPTH));
  assign slot_free      = !out_meta_valid || out_meta_ready;
  assign head_turn      = !fifo_empty &&
                          (!in_meta_valid || fifo_full || (burst_cnt == BW'(MAX_PKT_BURST)));
  assign in_meta_ready  = rst && slot_free && !head_turn;
  assign head_upd_ready = rst && !fifo_full;

  assign pkt_q     = in_meta_data.pkt_queue_id[QIDW-1 -: QW];
  assign head_q    = fifo_mem[rd_ptr];
  assign pkt_fire  = in_meta_valid && in_meta_ready;
  assign hu_fire   = head_upd_valid && head_upd_ready;
  assign pop       = rst && slot_free && head_turn;
  assign pkt_merge = pkt_fire && pending[pkt_q];
  assign pop_live  = pop && pending[head_q];
  assign hu_dup    = hu_fire && pending[head_upd_queue_id];
  assign push      = hu_fire && !pending[head_upd_queue_id];

  // Clears act on the pre-cycle pending state; a push only happens when the bit was 0
  always_comb begin
    pending_nxt = pending;
    if (pkt_merge) pending_nxt[pkt_q] = 1'b0;
    if (pop_live)  pending_nxt[head_q] = 1'b0;
    if (push)      pending_nxt[head_upd_queue_id] = 1'b1;
  end

  always_comb begin
    pkt_out                 = in_meta_data;
    pkt_out.needs_dsc       = pending[pkt_q];
    pkt_out.descriptor_only = 1'b0;
    dsc_out                 = '0;
    dsc_out.pkt_queue_id[QIDW-1 -: QW] = head_q;
    dsc_out.descriptor_only = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= head_upd_queue_id;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      pending        <= '0;
      burst_cnt      <= '0;
      out_meta_data  <= '0;
      out_meta_valid <= 1'b0;
      pkt_cnt        <= '0;
      dsc_only_cnt   <= '0;
      merged_cnt     <= '0;
      dup_cnt        <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      pending  <= pending_nxt;

      if (pop || fifo_empty) begin
        burst_cnt <= '0;
      end else if (pkt_fire && (burst_cnt != BW'(MAX_PKT_BURST))) begin
        burst_cnt <= burst_cnt + BW'(1);
      end

      // Stale pops leave the slot empty for that cycle
      if (slot_free) begin
        if (pkt_fire) begin
          out_meta_data  <= pkt_out;
          out_meta_valid <= 1'b1;
        end else if (pop_live) begin
          out_meta_data  <= dsc_out;
          out_meta_valid <= 1'b1;
        end else begin
          out_meta_valid <= 1'b0;
        end
      end

      pkt_cnt      <= pkt_cnt + 32'(pkt_fire);
      merged_cnt   <= merged_cnt + 32'(pkt_merge);
      dsc_only_cnt <= dsc_only_cnt + 32'(pop_live);
      dup_cnt      <= dup_cnt + 32'(hu_dup);
    end
  end

endmodule

// File: tb/tb_pkt_head_upd_merger.sv
// Directed bench for pkt_head_upd_merger: merge, descriptor-only, duplicate, burst, backpressure and reset cases.
module tb_pkt_head_upd_merger;
  import pkt_head_upd_merger_pkg::*;

  localparam int unsigned QW = 9;

  logic                  clk = 1'b0;
  logic                  rst;
  pkt_meta_with_queues_t in_meta_data;
  logic                  in_meta_valid;
  logic                  in_meta_ready;
  logic [QW-1:0]         head_upd_queue_id;
  logic                  head_upd_valid;
  logic                  head_upd_ready;
  pkt_meta_with_queues_t out_meta_data;
  logic                  out_meta_valid;
  logic                  out_meta_ready;
  logic [31:0]           pkt_cnt;
  logic [31:0]           dsc_only_cnt;
  logic [31:0]           merged_cnt;
  logic [31:0]           dup_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  pkt_meta_with_queues_t log_q[$];
  pkt_meta_with_queues_t exp_q[$];

  always #5 clk = ~clk;

  pkt_head_upd_merger dut (
    .clk               (clk),
    .rst               (rst),
    .in_meta_data      (in_meta_data),
    .in_meta_valid     (in_meta_valid),
    .in_meta_ready     (in_meta_ready),
    .head_upd_queue_id (head_upd_queue_id),
    .head_upd_valid    (head_upd_valid),
    .head_upd_ready    (head_upd_ready),
    .out_meta_data     (out_meta_data),
    .out_meta_valid    (out_meta_valid),
    .out_meta_ready    (out_meta_ready),
    .pkt_cnt           (pkt_cnt),
    .dsc_only_cnt      (dsc_only_cnt),
    .merged_cnt        (merged_cnt),
    .dup_cnt           (dup_cnt)
  );

  // Output monitor: record every completed output transfer
  always @(negedge clk) begin
    if (rst && out_meta_valid && out_meta_ready) log_q.push_back(out_meta_data);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pkt_meta_with_queues_t mk_pkt(input logic [QW-1:0] q, input logic [15:0] len,
                                                    input logic needs);
    mk_pkt = '0;
    mk_pkt.pkt_addr     = {16'hA000, len};
    mk_pkt.pkt_len      = len;
    mk_pkt.pkt_queue_id = {q, 7'h15};
    mk_pkt.needs_dsc    = needs;
  endfunction

  function automatic pkt_meta_with_queues_t mk_dsc(input logic [QW-1:0] q);
    mk_dsc = '0;
    mk_dsc.pkt_queue_id    = {q, 7'h00};
    mk_dsc.descriptor_only = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    in_meta_valid  = 1'b0;
    head_upd_valid = 1'b0;
    out_meta_ready = 1'b1;
    idle(2);
    rst = 1'b1;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_pkt(input pkt_meta_with_queues_t p);
    in_meta_data  = p;
    in_meta_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_meta_ready) begin
        tick();
        return;
      end
      tick();
    end
    check("pkt_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic drive_hu(input logic [QW-1:0] q);
    head_upd_queue_id = q;
    head_upd_valid    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (head_upd_ready) begin
        tick();
        head_upd_valid = 1'b0;
        return;
      end
      tick();
    end
    head_upd_valid = 1'b0;
    check("hu_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    rst               = 1'b0;
    in_meta_data      = mk_pkt(9'd1, 16'h1, 1'b0);
    in_meta_valid     = 1'b1;
    head_upd_queue_id = 9'd1;
    head_upd_valid    = 1'b1;
    out_meta_ready    = 1'b1;
    idle(3);

    // Reset state with both inputs requesting
    @(negedge clk);
    check("rst_out_valid", 128'(out_meta_valid), 128'(0));
    check("rst_out_data", 128'(out_meta_data), 128'(0));
    check("rst_in_ready", 128'(in_meta_ready), 128'(0));
    check("rst_hu_ready", 128'(head_upd_ready), 128'(0));
    check("rst_cnts", 128'({pkt_cnt, dsc_only_cnt, merged_cnt, dup_cnt}), 128'(0));
    tick();

    // Plain packet, one-cycle latency
    do_reset();
    drive_pkt(mk_pkt(9'd5, 16'h40, 1'b0));
    in_meta_valid = 1'b0;
    @(negedge clk);
    check("p5_valid", 128'(out_meta_valid), 128'(1));
    check("p5_data", 128'(out_meta_data), 128'(mk_pkt(9'd5, 16'h40, 1'b0)));
    check("p5_pkt_cnt", 128'(pkt_cnt), 128'(1));
    tick();

    // Head update on idle stream, then packet to same queue is not merged
    do_reset();
    drive_hu(9'd3);
    idle(3);
    exp_q.push_back(mk_dsc(9'd3));
    check_log("hu3");
    check("hu3_dsc_cnt", 128'(dsc_only_cnt), 128'(1));
    drive_pkt(mk_pkt(9'd3, 16'h33, 1'b0));
    in_meta_valid = 1'b0;
    idle(3);
    exp_q.push_back(mk_pkt(9'd3, 16'h33, 1'b0));
    check_log("hu3_after");

    // Merge: packet catches pending q7, stale pop emits nothing
    do_reset();
    drive_hu(9'd7);
    drive_pkt(mk_pkt(9'd7, 16'h77, 1'b0));
    in_meta_valid = 1'b0;
    idle(4);
    exp_q.push_back(mk_pkt(9'd7, 16'h77, 1'b1));
    check_log("merge7");
    check("merge7_cnts", 128'({pkt_cnt, dsc_only_cnt, merged_cnt}), 128'({32'd1, 32'd0, 32'd1}));

    // Same-cycle head update and packet to q4: packet not merged
    do_reset();
    head_upd_queue_id = 9'd4;
    head_upd_valid    = 1'b1;
    drive_pkt(mk_pkt(9'd4, 16'h44, 1'b0));
    head_upd_valid = 1'b0;
    in_meta_valid  = 1'b0;
    idle(4);
    exp_q.push_back(mk_pkt(9'd4, 16'h44, 1'b0));
    exp_q.push_back(mk_dsc(9'd4));
    check_log("same4");
    check("same4_merged", 128'(merged_cnt), 128'(0));

    // Duplicate head updates to q2 while packets to q1 flow
    do_reset();
    for (int i = 0; i < 3; i++) begin
      head_upd_queue_id = 9'd2;
      head_upd_valid    = 1'b1;
      drive_pkt(mk_pkt(9'd1, 16'(i), 1'b0));
      exp_q.push_back(mk_pkt(9'd1, 16'(i), 1'b0));
    end
    head_upd_valid = 1'b0;
    in_meta_valid  = 1'b0;
    idle(4);
    exp_q.push_back(mk_dsc(9'd2));
    check_log("dup2");
    check("dup2_dup_cnt", 128'(dup_cnt), 128'(2));
    check("dup2_dsc_cnt", 128'(dsc_only_cnt), 128'(1));

    // Burst limit: q9 descriptor forced in after 8 waiting packets
    do_reset();
    head_upd_queue_id = 9'd9;
    head_upd_valid    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_pkt(mk_pkt(9'd1, 16'(16'h100 + i), 1'b0));
      if (i == 0) head_upd_valid = 1'b0;
    end
    in_meta_valid = 1'b0;
    idle(3);
    for (int i = 0; i < 12; i++) begin
      if (i == 9) exp_q.push_back(mk_dsc(9'd9));
      exp_q.push_back(mk_pkt(9'd1, 16'(16'h100 + i), 1'b0));
    end
    check_log("burst");

    // Output backpressure for 10 cycles
    do_reset();
    out_meta_ready = 1'b0;
    drive_pkt(mk_pkt(9'd10, 16'hA, 1'b0));
    in_meta_data = mk_pkt(9'd11, 16'hB, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(out_meta_valid), 128'(1));
      check("bp_data", 128'(out_meta_data), 128'(mk_pkt(9'd10, 16'hA, 1'b0)));
      check("bp_in_ready", 128'(in_meta_ready), 128'(0));
      tick();
    end
    out_meta_ready = 1'b1;
    drive_pkt(mk_pkt(9'd11, 16'hB, 1'b0));
    in_meta_valid = 1'b0;
    idle(3);
    exp_q.push_back(mk_pkt(9'd10, 16'hA, 1'b0));
    exp_q.push_back(mk_pkt(9'd11, 16'hB, 1'b0));
    check_log("bp");
    check("bp_pkt_cnt", 128'(pkt_cnt), 128'(2));

    // Fill the FIFO with 16 distinct updates while output is blocked
    do_reset();
    out_meta_ready = 1'b0;
    drive_pkt(mk_pkt(9'd12, 16'hC, 1'b0));
    in_meta_valid = 1'b0;
    for (int i = 0; i < 16; i++) drive_hu(9'(20 + i));
    @(negedge clk);
    check("full_hu_ready", 128'(head_upd_ready), 128'(0));
    tick();
    head_upd_queue_id = 9'd40;
    head_upd_valid    = 1'b1;
    idle(3);
    @(negedge clk);
    check("full_hu_ready_hold", 128'(head_upd_ready), 128'(0));
    check("full_dup_cnt", 128'(dup_cnt), 128'(0));
    tick();
    out_meta_ready = 1'b1;
    drive_hu(9'd40);
    idle(25);
    exp_q.push_back(mk_pkt(9'd12, 16'hC, 1'b0));
    for (int i = 0; i < 16; i++) exp_q.push_back(mk_dsc(9'(20 + i)));
    exp_q.push_back(mk_dsc(9'd40));
    check_log("full");
    check("full_dsc_cnt", 128'(dsc_only_cnt), 128'(17));

    // Reset mid-stream discards output register and queued updates
    out_meta_ready = 1'b0;
    drive_pkt(mk_pkt(9'd13, 16'hD, 1'b0));
    in_meta_valid = 1'b0;
    drive_hu(9'd50);
    drive_hu(9'd51);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_valid", 128'(out_meta_valid), 128'(0));
    check("mid_rst_data", 128'(out_meta_data), 128'(0));
    check("mid_rst_readies", 128'({in_meta_ready, head_upd_ready}), 128'(0));
    check("mid_rst_cnts", 128'({pkt_cnt, dsc_only_cnt, merged_cnt, dup_cnt}), 128'(0));
    tick();
    rst            = 1'b1;
    out_meta_ready = 1'b1;
    log_q.delete();
    exp_q.delete();
    idle(5);
    check_log("mid_rst_quiet");
    @(negedge clk);
    check("mid_rst_hu_ready", 128'(head_upd_ready), 128'(1));
    tick();
    drive_pkt(mk_pkt(9'd50, 16'hE, 1'b0));
    in_meta_valid = 1'b0;
    idle(3);
    exp_q.push_back(mk_pkt(9'd50, 16'hE, 1'b0));
    check_log("mid_rst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
